// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Multi-cycle sequencer for MIPS DIV / DIVU with a radix-2 restoring
// shift-subtract datapath. It sits in EX beside the ALU. It freezes the
// pipeline through stall_o while a division is in flight. It returns
// {HI = remainder, LO = quotient} together with a single-cycle ready_o.
//
// Handshake: EX raises start_i and holds it until it has seen ready_o.
// ready_o is high for exactly one cycle per accepted start. The controller
// then waits in END until start_i drops, so a held start never launches a
// second division. annul_i (exception flush) aborts any division in flight.
// No ready_o is issued for an aborted division.
//
// Optional feature (define the macro to enable):
//   DIV_EARLY_FINISH_EN - when |dividend| < |divisor| and the divisor is
//                         nonzero, skip the iterations. The result is then
//                         Q = 0, R = original dividend, ready two cycles after
//                         start. The results are identical with the macro
//                         undefined; only the latency differs.
//
// Parameters:
//   WIDTH      operand width (result_o is 2*WIDTH)
//   CNT_W      iteration counter width, 2**CNT_W > WIDTH
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   start_i    division request from EX
//   signed_i   1 = DIV (signed), 0 = DIVU
//   annul_i    exception flush, aborts the division in flight
//   opdata1_i  dividend (rs)
//   opdata2_i  divisor (rt)
//   result_o   {remainder, quotient}, changes only on entry to END
//   ready_o    result valid, one cycle per accepted start
//   stall_o    pipeline stall request (combinational)
//   dbg_state  current FSM state: 0 IDLE, 1 DIVZERO, 2 ON, 3 END
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               sign1_q;
    logic               sign2_q;
    logic               signed_q;

    // Operand magnitudes. The negation is taken only for signed ops.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic               early;
    logic               accept;

    // One restoring iteration.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               trial_neg;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic               last_iter;

    always_comb begin
        abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        accept = start_i && !annul_i;
`ifdef DIV_EARLY_FINISH_EN
        early = (abs1 < abs2);
`else
        early = 1'b0;
`endif

        // The shifted remainder can reach 2*divisor-1, so it needs one bit
        // beyond WIDTH. The trial is kept one bit wider again so that its
        // top bit is a clean borrow flag.
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        trial     = {1'b0, rem_sh} - {2'b00, divisor_q};
        trial_neg = trial[WIDTH+1];
        rem_nxt   = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ~trial_neg};

        // Truncating-division sign rules. The quotient follows the XOR of
        // the operand signs. The remainder follows the dividend.
        quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quo_nxt : quo_nxt;
        rem_fix = (signed_q && sign1_q) ? -rem_nxt : rem_nxt;

        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            signed_q  <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        divisor_q <= abs2;
                        sign1_q   <= opdata1_i[WIDTH-1];
                        sign2_q   <= opdata2_i[WIDTH-1];
                        signed_q  <= signed_i;
                        cnt       <= '0;
                        if (opdata2_i == '0) begin
                            // DIVZERO hands {rem_q, quo_q} straight to
                            // result_o, so preload the zero result.
                            state <= ST_DIVZERO;
                            rem_q <= '0;
                            quo_q <= '0;
                        end else if (early) begin
                            // Same single-cycle path, preloaded with
                            // Q = 0 and R = the raw dividend.
                            state <= ST_DIVZERO;
                            rem_q <= opdata1_i;
                            quo_q <= '0;
                        end else begin
                            state <= ST_ON;
                            rem_q <= '0;
                            quo_q <= abs1;
                        end
                    end
                end

                ST_DIVZERO: begin
                    if (annul_i) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_END;
                        result_o <= {rem_q, quo_q};
                        ready_o  <= 1'b1;
                    end
                end

                ST_ON: begin
                    if (annul_i) begin
                        state <= ST_IDLE;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt   <= cnt + 1'b1;
                        if (last_iter) begin
                            state    <= ST_END;
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end

                ST_END: begin
                    // Wait here until EX drops start so one request yields
                    // exactly one result.
                    if (annul_i || !start_i) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // stall_o is low in END so the pipeline advances in the ready cycle.
    // It drops immediately on annul.
    always_comb begin
        stall_o = ((state == ST_IDLE) && start_i && !annul_i) ||
                  (((state == ST_DIVZERO) || (state == ST_ON)) && !annul_i);
        dbg_state = state;
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
//
// Directed and random DIV/DIVU operations against div_seq_ctrl. Expected
// results come from a reference model that uses plain 64-bit arithmetic.
// Expected latency follows the documented start-to-ready cycle counts.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start_i;
    logic           signed_i;
    logic           annul_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stall_o;
    logic [1:0]     dbg_state;

    int             vectors;
    int             miscompares;
    logic [2*W-1:0] last_result;
    logic [2*W-1:0] exp_q[$];

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .annul_i   (annul_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o),
        .dbg_state (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: truncating division, with Q = R = 0 for a zero
    // divisor. Returns {remainder, quotient}.
    function automatic logic [2*W-1:0] model(input logic sgn,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == 0) return '0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Start-to-ready latency in cycles.
    function automatic int latency(input logic sgn,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        longint ma, mb;
        if (b == 0) return 2;
        ma = sgn ? longint'($signed(a)) : longint'(a);
        mb = sgn ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_FINISH_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return W + 1;
`endif
        return W + 1;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs,
                         input logic [2*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: one full operation. Start is held for `hold` extra cycles
    // after ready. A positive annul_at pulses annul_i in that cycle.
    task automatic do_div(input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold,
                          input int annul_at);
        int lat;
        logic [2*W-1:0] exp;
        lat = latency(sgn, a, b);
        exp_q.push_back(model(sgn, a, b));
        @(posedge clk); #1;
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        @(negedge clk);
        check("stall_c0", 64'(stall_o), 64'd1);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c == annul_at) annul_i = 1'b1;
            if (annul_at > 0 && c == annul_at + 1) begin
                start_i = 1'b0;
                annul_i = 1'b0;
            end
            @(negedge clk);
            if (annul_at > 0 && c == annul_at) begin
                check("stall_annul", 64'(stall_o), 64'd0);
            end else if (annul_at > 0 && c == annul_at + 1) begin
                check("idle_after_annul", 64'(dbg_state), 64'd0);
                check("no_ready_annul", 64'(ready_o), 64'd0);
                check("result_kept", result_o, last_result);
                void'(exp_q.pop_front());
                return;
            end else begin
                check($sformatf("rdy_stall_c%0d", c), 64'({ready_o, stall_o}),
                      64'({c == lat, c < lat}));
            end
        end
        exp = exp_q.pop_front();
        check("result", result_o, exp);
        last_result = exp;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_no_repulse", 64'({ready_o, stall_o}), 64'd0);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("back_to_idle", 64'(dbg_state), 64'd0);
        check("result_held", result_o, exp);
    endtask

    initial begin
        logic sgn;
        logic [W-1:0] a, b;
        vectors     = 0;
        miscompares = 0;
        last_result = '0;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {result_o[61:0], ready_o, stall_o}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases.
        do_div(1'b0, 32'd7, 32'd2, 0, 0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_div(1'b1, 32'd5, 32'd0, 0, 0);
        do_div(1'b0, 32'd100, 32'd3, 0, 10);
        do_div(1'b0, 32'd9, 32'd3, 0, 0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0);
        do_div(1'b0, 32'd3, 32'd10, 0, 0);
        do_div(1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0);
        do_div(1'b1, 32'd17, 32'hFFFF_FFFB, 1, 0);

        // Random operations with a mix of divisor magnitudes and zero.
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = $urandom;
                default: b = -($urandom_range(1, 300));
            endcase
            if (i % 6 == 5) a = $urandom_range(0, 50);
            do_div(sgn, a, b, $urandom_range(0, 2), 0);
        end

        // Reset in the middle of a division, with start still asserted.
        @(posedge clk); #1;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        check("rst_mid_ready", 64'({ready_o, stall_o}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_result = '0;
        do_div(1'b0, 32'd1000, 32'd7, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
